// File: rtl/pwl_act_pkg.sv
// pwl_act_pkg: shared constants and helpers for the piecewise-linear activation pipe.
//   CFG_SEL_*    : cfg_sel encodings for table writes (3 is accepted and ignored)
//   sat_s()      : signed saturation of a 64-bit value to an arbitrary width
//   SILU_*       : default SiLU table (Q7.9, 32 segments, knots every 0.5 on [-8, 8])
//                  for software / bench loading; not used by the datapath itself.
package pwl_act_pkg;

    localparam logic [1:0] CFG_SEL_BP    = 2'd0;
    localparam logic [1:0] CFG_SEL_SLOPE = 2'd1;
    localparam logic [1:0] CFG_SEL_ICPT  = 2'd2;

    // Clamp v into the signed range of 'width' bits.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // SiLU(x)*512 sampled at x = -8.0 + 0.5*k, k = 0..32.
    localparam int SILU_SEG_N = 32;
    localparam int SILU_KNOT [33] = '{
          -1,   -2,   -3,   -5,   -8,  -11,  -17,  -25,
         -37,  -53,  -73,  -97, -122, -140, -138,  -97,
           0,  159,  374,  628,  902, 1183, 1463, 1739,
        2011, 2279, 2543, 2805, 3064, 3323, 3581, 3838,
        4095
    };

    // Breakpoint i sits at the upper knot of segment i: -7.5 + 0.5*i.
    function automatic logic [15:0] silu_bp(input int i);
        return 16'((i - 15) * 256);
    endfunction

    // Chord slope across segment k (knot spacing 0.5, so slope = 2*dy in Q9).
    function automatic logic [15:0] silu_slope(input int k);
        return 16'(2 * (SILU_KNOT[k + 1] - SILU_KNOT[k]));
    endfunction

    // Intercept so the chord passes through the lower knot of segment k.
    function automatic logic [15:0] silu_icpt(input int k);
        int s;
        int xk;
        s  = 2 * (SILU_KNOT[k + 1] - SILU_KNOT[k]);
        xk = (k - 16) * 256;
        return 16'(SILU_KNOT[k] - ((s * xk) >>> 9));
    endfunction

endpackage

// File: rtl/pwl_act_pipe_lane.sv
// pwl_seg_lane: one lane of the PWL activation pipe.
//   S1: register x and its segment index (priority compare against shared breakpoints)
//   S2: register full-width slope*x and the segment intercept
//   S3: register the saturated result
// Ports: clk, rst (async high), adv (global stage enable), x (lane sample),
//        bp/slope/icpt (shared tables), y (S3 result).
module pwl_seg_lane
    import pwl_act_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 9,
    parameter int SEG_N  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         adv,
    input  logic [DATA_W-1:0]            x,
    input  logic [SEG_N-2:0][DATA_W-1:0] bp,
    input  logic [SEG_N-1:0][DATA_W-1:0] slope,
    input  logic [SEG_N-1:0][DATA_W-1:0] icpt,
    output logic [DATA_W-1:0]            y
);
    localparam int SEG_W = $clog2(SEG_N);

    logic [SEG_W-1:0]           seg_c;
    logic signed [DATA_W-1:0]   x1;
    logic [SEG_W-1:0]           seg1;
    logic signed [2*DATA_W-1:0] prod_c;
    logic signed [2*DATA_W-1:0] prod2;
    logic signed [DATA_W-1:0]   icpt2;
    logic signed [2*DATA_W-1:0] q_c;
    logic signed [63:0]         q_sat;
    logic signed [DATA_W+1:0]   r_c;
    logic signed [63:0]         r_sat;
    logic [DATA_W-1:0]          y_c;

    // Lowest matching breakpoint wins: scan high-to-low so the last hit is the lowest.
    always_comb begin
        seg_c = SEG_W'(SEG_N - 1);
        for (int i = SEG_N - 2; i >= 0; i--) begin
            if ($signed(x) < $signed(bp[i])) seg_c = SEG_W'(i);
        end
    end

    assign prod_c = (2*DATA_W)'($signed(slope[seg1])) * (2*DATA_W)'(x1);

    // q is pre-clamped to DATA_W+1 bits so the intercept add cannot wrap in DATA_W+2
    // bits; any q outside that range saturates the final result the same way anyway.
    always_comb begin
        q_c   = prod2 >>> FRAC_W;
        q_sat = sat_s(64'(q_c), DATA_W + 1);
        r_c   = (DATA_W+2)'(q_sat) + (DATA_W+2)'(icpt2);
        r_sat = sat_s(64'(r_c), DATA_W);
        y_c   = DATA_W'(r_sat);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1    <= '0;
            seg1  <= '0;
            prod2 <= '0;
            icpt2 <= '0;
            y     <= '0;
        end else if (adv) begin
            x1    <= x;
            seg1  <= seg_c;
            prod2 <= prod_c;
            icpt2 <= icpt[seg1];
            y     <= y_c;
        end
    end

endmodule

// File: rtl/pwl_act_pipe.sv
// pwl_act_pipe: 3-stage, table-programmable piecewise-linear activation unit.
//   y = sat(((slope[s]*x) >>> FRAC_W) + intercept[s]) per lane, s from shared breakpoints.
// Ports:
//   clk, rst (async high)
//   in_valid/in_ready/in_data   : input beats, lane i at [i*DATA_W +: DATA_W]
//   out_valid/out_ready/out_data: results, same packing
//   cfg_valid/cfg_ready/cfg_sel/cfg_addr/cfg_data: table writes, only with pipeline empty
module pwl_act_pipe
    import pwl_act_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 9,
    parameter int SEG_N  = 32,
    parameter int LANES  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   out_data,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [1:0]                cfg_sel,
    input  logic [$clog2(SEG_N)-1:0]  cfg_addr,
    input  logic [DATA_W-1:0]         cfg_data
);
    localparam int SEG_W  = $clog2(SEG_N);
    localparam int STAGES = 3;
    localparam logic [DATA_W-1:0] BP_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    logic [STAGES:1]                vld_pipe;
    logic                           adv;
    logic                           in_fire;
    logic                           cfg_fire;
    logic [SEG_N-2:0][DATA_W-1:0]   bp;
    logic [SEG_N-1:0][DATA_W-1:0]   slope;
    logic [SEG_N-1:0][DATA_W-1:0]   icpt;
    logic [LANES-1:0][DATA_W-1:0]   lane_x;
    logic [LANES-1:0][DATA_W-1:0]   lane_y;

    // Global-enable pipeline: every stage moves together or nothing moves.
    assign adv       = ~vld_pipe[STAGES] | out_ready;
    assign in_ready  = adv & ~cfg_valid;
    assign in_fire   = in_valid & in_ready;
    assign cfg_ready = ~|vld_pipe;
    assign cfg_fire  = cfg_valid & cfg_ready;
    assign out_valid = vld_pipe[STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      vld_pipe <= '0;
        else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], in_fire};
    end

    // Breakpoint table has SEG_N-1 entries; address SEG_N-1 has no backing flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp    <= {(SEG_N-1){BP_MAX}};
            slope <= '0;
            icpt  <= '0;
        end else if (cfg_fire) begin
            case (cfg_sel)
                CFG_SEL_BP:    if (cfg_addr != SEG_W'(SEG_N - 1)) bp[cfg_addr] <= cfg_data;
                CFG_SEL_SLOPE: slope[cfg_addr] <= cfg_data;
                CFG_SEL_ICPT:  icpt[cfg_addr]  <= cfg_data;
                default: ;
            endcase
        end
    end

    assign lane_x   = in_data;
    assign out_data = lane_y;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        pwl_seg_lane #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W),
            .SEG_N  (SEG_N)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .adv   (adv),
            .x     (lane_x[l]),
            .bp    (bp),
            .slope (slope),
            .icpt  (icpt),
            .y     (lane_y[l])
        );
    end

endmodule
